// File: rtl/pdec_updt_pm_lx.sv
// List-decoder PM update: per path, LLR penalties accumulate over beats into 4 candidate PMs, registered 1 clk after the last beat.
// No backpressure (beats always accepted); optional PDEC_UPM_MINNORM_EN adds a min-cand0 normalisation cycle before upm2ctrl_upm_done.
module pdec_updt_pm_lx #(
  parameter int WID_PM   = 10,
  parameter int WID_INN  = 10,
  parameter int NUM_PATH = 8,
  parameter int NUM_LLR  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  output logic                                pdec_clk_en3,
  input  logic [2:0]                          cur_jump_type,
  input  logic [2*NUM_PATH-1:0]               path_valid,
  input  logic [1:0]                          ctrl2upm_pm_src_ind,
  output logic                                upm2ctrl_upm_done,
  input  logic [NUM_PATH-1:0]                 ulr2upm_llr_st,
  input  logic [NUM_PATH-1:0]                 ulr2upm_llr_en,
  input  logic [NUM_PATH-1:0]                 ulr2upm_llr_last,
  input  logic [WID_INN*NUM_LLR*NUM_PATH-1:0] ulr2upm_llr_data,
  output logic [2*4*NUM_PATH-1:0]             upm2uph_bit_val,
  output logic [WID_PM*4*NUM_PATH-1:0]        upm2srt_pm_val,
  input  logic [WID_PM*NUM_PATH-1:0]          srt2upm_pm_val
);

  localparam int SW = ((WID_PM > WID_INN) ? WID_PM : WID_INN) + $clog2(NUM_LLR) + 2;
  localparam logic [WID_PM-1:0] PM_MAX = {WID_PM{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FIN} state_e;
  typedef enum logic [1:0] {T_FRZ, T_REP, T_INF, T_NRM} ntype_e;

  state_e            state_q [NUM_PATH];
  state_e            state_d [NUM_PATH];
  ntype_e            ntype_q [NUM_PATH];
  ntype_e            ntype_d [NUM_PATH];
  logic [WID_PM-1:0] acc_q   [NUM_PATH][4];
  logic [WID_PM-1:0] acc_d   [NUM_PATH][4];
  logic [WID_PM-1:0] pm_q    [NUM_PATH][4];
  logic [WID_PM-1:0] pm_d    [NUM_PATH][4];
  logic [1:0]        bit_q   [NUM_PATH][4];
  logic [1:0]        bit_d   [NUM_PATH][4];
  logic [SW-1:0]     psum    [NUM_PATH][4];
  logic [WID_PM-1:0] base_pm [NUM_PATH];
  logic [NUM_PATH-1:0] mask_q, mask_d;
  logic done_q, done_d;
  logic norm_q;
`ifdef PDEC_UPM_MINNORM_EN
  logic norm_d;
  logic [WID_PM-1:0] min_pm;
`endif

  function automatic ntype_e map_type(input logic [2:0] t);
    case (t)
      3'd0:    map_type = T_FRZ;
      3'd1:    map_type = T_REP;
      3'd2:    map_type = T_INF;
      default: map_type = T_NRM;
    endcase
  endfunction

  // The most negative LLR negates onto itself; read unsigned it is exactly 2^(WID_INN-1).
  function automatic logic [SW-1:0] pen(input logic [WID_INN-1:0] x, input logic b);
    logic [WID_INN-1:0] mag;
    mag = x[WID_INN-1] ? (~x + WID_INN'(1)) : x;
    pen = (x[WID_INN-1] != b) ? SW'(mag) : '0;
  endfunction

  function automatic logic [WID_PM-1:0] sat_add(input logic [WID_PM-1:0] a, input logic [SW-1:0] p);
    logic [SW-1:0] s;
    s = SW'(a) + p;
    sat_add = (s > SW'(PM_MAX)) ? PM_MAX : s[WID_PM-1:0];
  endfunction

  function automatic logic cand_unused(input ntype_e t, input int k);
    case (t)
      T_FRZ:   cand_unused = (k != 0);
      T_INF:   cand_unused = 1'b0;
      default: cand_unused = (k >= 2);
    endcase
  endfunction

  function automatic logic [1:0] cand_bits(input ntype_e t, input int k);
    case (t)
      T_REP:   cand_bits = (k == 1) ? 2'b11 : 2'b00;
      T_INF:   cand_bits = 2'(k);
      T_NRM:   cand_bits = (k == 1) ? 2'b01 : 2'b00;
      default: cand_bits = 2'b00;
    endcase
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_PATH; p++) begin
      case (ctrl2upm_pm_src_ind)
        2'd1:    base_pm[p] = pm_q[p][0];
        2'd2:    base_pm[p] = srt2upm_pm_val[p*WID_PM +: WID_PM];
        default: base_pm[p] = '0;
      endcase
    end
  end

  // Per-beat penalty of each candidate hypothesis; frozen only consumes cand0.
  always_comb begin
    for (int p = 0; p < NUM_PATH; p++) begin
      for (int k = 0; k < 4; k++) psum[p][k] = '0;
      case (ntype_q[p])
        T_FRZ, T_REP: begin
          for (int j = 0; j < NUM_LLR; j++) begin
            psum[p][0] = psum[p][0] + pen(ulr2upm_llr_data[(p*NUM_LLR+j)*WID_INN +: WID_INN], 1'b0);
            psum[p][1] = psum[p][1] + pen(ulr2upm_llr_data[(p*NUM_LLR+j)*WID_INN +: WID_INN], 1'b1);
          end
        end
        T_INF: begin
          for (int k = 0; k < 4; k++)
            psum[p][k] = pen(ulr2upm_llr_data[(p*NUM_LLR)*WID_INN +: WID_INN], 1'(k))
                       + pen(ulr2upm_llr_data[(p*NUM_LLR+1)*WID_INN +: WID_INN], 1'(k >> 1));
        end
        default: begin
          psum[p][0] = pen(ulr2upm_llr_data[(p*NUM_LLR)*WID_INN +: WID_INN], 1'b0);
          psum[p][1] = pen(ulr2upm_llr_data[(p*NUM_LLR)*WID_INN +: WID_INN], 1'b1);
        end
      endcase
    end
  end

`ifdef PDEC_UPM_MINNORM_EN
  always_comb begin
    min_pm = PM_MAX;
    for (int p = 0; p < NUM_PATH; p++)
      if (path_valid[2*p +: 2] == 2'b01 && pm_q[p][0] < min_pm) min_pm = pm_q[p][0];
  end
`endif

  // Outputs are captured on the edge entering FIN, so they are visible during FIN together with done.
  always_comb begin
    mask_d = mask_q;
    for (int p = 0; p < NUM_PATH; p++) begin
      state_d[p] = state_q[p];
      ntype_d[p] = ntype_q[p];
      for (int k = 0; k < 4; k++) begin
        acc_d[p][k] = acc_q[p][k];
        bit_d[p][k] = bit_q[p][k];
        pm_d[p][k]  = pm_q[p][k];
`ifdef PDEC_UPM_MINNORM_EN
        if (norm_q && path_valid[2*p +: 2] == 2'b01 && pm_q[p][k] != PM_MAX)
          pm_d[p][k] = (pm_q[p][k] > min_pm) ? pm_q[p][k] - min_pm : '0;
`endif
      end
      if (ulr2upm_llr_st[p]) begin
        state_d[p] = S_ACC;
        ntype_d[p] = map_type(cur_jump_type);
        mask_d[p]  = 1'b1;
        for (int k = 0; k < 4; k++) acc_d[p][k] = base_pm[p];
      end else if (state_q[p] == S_ACC && ulr2upm_llr_en[p]) begin
        for (int k = 0; k < 4; k++)
          if (path_valid[2*p] || ntype_q[p] == T_FRZ) acc_d[p][k] = sat_add(acc_q[p][k], psum[p][k]);
        if (ulr2upm_llr_last[p] || ntype_q[p] == T_INF || ntype_q[p] == T_NRM) begin
          state_d[p] = S_FIN;
          mask_d[p]  = 1'b0;
          for (int k = 0; k < 4; k++) begin
            if (path_valid[2*p +: 2] == 2'b11) begin
              pm_d[p][k]  = PM_MAX;
              bit_d[p][k] = 2'b00;
            end else begin
              pm_d[p][k]  = cand_unused(ntype_q[p], k) ? PM_MAX : acc_d[p][k];
              bit_d[p][k] = cand_bits(ntype_q[p], k);
            end
          end
        end
      end else if (state_q[p] == S_FIN) begin
        state_d[p] = S_IDLE;
      end
    end
  end

  always_comb begin
`ifdef PDEC_UPM_MINNORM_EN
    norm_d = (|mask_q) && !(|mask_d);
    done_d = norm_q;
`else
    done_d = (|mask_q) && !(|mask_d);
`endif
  end

`ifndef PDEC_UPM_MINNORM_EN
  assign norm_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      done_q <= 1'b0;
`ifdef PDEC_UPM_MINNORM_EN
      norm_q <= 1'b0;
`endif
      for (int p = 0; p < NUM_PATH; p++) begin
        state_q[p] <= S_IDLE;
        ntype_q[p] <= T_NRM;
        for (int k = 0; k < 4; k++) begin
          acc_q[p][k] <= '0;
          pm_q[p][k]  <= '0;
          bit_q[p][k] <= '0;
        end
      end
    end else begin
      mask_q <= mask_d;
      done_q <= done_d;
`ifdef PDEC_UPM_MINNORM_EN
      norm_q <= norm_d;
`endif
      for (int p = 0; p < NUM_PATH; p++) begin
        state_q[p] <= state_d[p];
        ntype_q[p] <= ntype_d[p];
        for (int k = 0; k < 4; k++) begin
          acc_q[p][k] <= acc_d[p][k];
          pm_q[p][k]  <= pm_d[p][k];
          bit_q[p][k] <= bit_d[p][k];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PATH; p++) begin
      for (int k = 0; k < 4; k++) begin
        upm2srt_pm_val[(p*4+k)*WID_PM +: WID_PM] = pm_q[p][k];
        upm2uph_bit_val[(p*4+k)*2 +: 2]          = bit_q[p][k];
      end
    end
  end

  assign upm2ctrl_upm_done = done_q;
  assign pdec_clk_en3      = (|ulr2upm_llr_st) | (|mask_q) | norm_q;

endmodule

// File: tb/tb_pdec_updt_pm_lx.sv
// Directed bench for pdec_updt_pm_lx: hand-computed PMs, bit hypotheses, done timing and clock-enable per scenario.
module tb_pdec_updt_pm_lx;
  localparam int WID_PM = 10, WID_INN = 10, NUM_PATH = 8, NUM_LLR = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic pdec_clk_en3, upm_done;
  logic [2:0] cur_jump_type;
  logic [2*NUM_PATH-1:0] path_valid;
  logic [1:0] src;
  logic [NUM_PATH-1:0] st, en, last;
  logic [WID_INN*NUM_LLR*NUM_PATH-1:0] llr_data;
  logic [2*4*NUM_PATH-1:0] bit_val;
  logic [WID_PM*4*NUM_PATH-1:0] pm_val;
  logic [WID_PM*NUM_PATH-1:0] srt_val;
  int total = 0, bad = 0;

  pdec_updt_pm_lx #(.WID_PM(WID_PM), .WID_INN(WID_INN), .NUM_PATH(NUM_PATH), .NUM_LLR(NUM_LLR)) dut (
    .clk(clk), .rst_n(rst_n), .pdec_clk_en3(pdec_clk_en3), .cur_jump_type(cur_jump_type),
    .path_valid(path_valid), .ctrl2upm_pm_src_ind(src), .upm2ctrl_upm_done(upm_done),
    .ulr2upm_llr_st(st), .ulr2upm_llr_en(en), .ulr2upm_llr_last(last), .ulr2upm_llr_data(llr_data),
    .upm2uph_bit_val(bit_val), .upm2srt_pm_val(pm_val), .srt2upm_pm_val(srt_val)
  );

  always #5 clk = ~clk;

  function automatic logic [WID_PM-1:0] pm(input int p, input int k);
    return pm_val[(p*4+k)*WID_PM +: WID_PM];
  endfunction

  function automatic logic [1:0] bv(input int p, input int k);
    return bit_val[(p*4+k)*2 +: 2];
  endfunction

  task automatic set_llr(input int p, input int j, input int v);
    llr_data[(p*NUM_LLR+j)*WID_INN +: WID_INN] = WID_INN'(v);
  endtask

  task automatic set_srt(input int p, input int v);
    srt_val[p*WID_PM +: WID_PM] = WID_PM'(v);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (pm_val !== '0) begin bad++; $display("FAIL reset_pm: got %h exp 0", pm_val); end
    total++; if (bit_val !== '0) begin bad++; $display("FAIL reset_bv: got %h exp 0", bit_val); end
    total++; if (upm_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b exp 0", upm_done); end
    total++; if (pdec_clk_en3 !== 1'b0) begin bad++; $display("FAIL reset_clken: got %b exp 0", pdec_clk_en3); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal();
    int exp_pm [4];
    int exp_bv [4];
    exp_pm = '{5, 0, 1023, 1023};
    exp_bv = '{0, 1, 0, 0};
    cur_jump_type = 3'd7; src = 2'd0; st[0] = 1'b1;
    @(negedge clk);
    st = '0; set_llr(0, 0, -5); en[0] = 1'b1;
    total++; if (pdec_clk_en3 !== 1'b1) begin bad++; $display("FAIL normal_clken_busy: got %b exp 1", pdec_clk_en3); end
    total++; if (upm_done !== 1'b0) begin bad++; $display("FAIL normal_done_early: got %b exp 0", upm_done); end
    @(negedge clk);
    en = '0;
    total++; if (upm_done !== 1'b1) begin bad++; $display("FAIL normal_done: got %b exp 1", upm_done); end
    for (int k = 0; k < 4; k++) begin
      total++; if (pm(0, k) !== WID_PM'(exp_pm[k])) begin bad++; $display("FAIL normal_pm%0d: got %0d exp %0d", k, pm(0, k), exp_pm[k]); end
      total++; if (bv(0, k) !== 2'(exp_bv[k])) begin bad++; $display("FAIL normal_bv%0d: got %0d exp %0d", k, bv(0, k), exp_bv[k]); end
    end
    @(negedge clk);
    total++; if (upm_done !== 1'b0) begin bad++; $display("FAIL normal_done_pulse: got %b exp 0", upm_done); end
    total++; if (pdec_clk_en3 !== 1'b0) begin bad++; $display("FAIL normal_clken_idle: got %b exp 0", pdec_clk_en3); end
  endtask

  task automatic test_rep();
    int exp_pm [4];
    int exp_bv [4];
    exp_pm = '{19, 20, 1023, 1023};
    exp_bv = '{0, 3, 0, 0};
    cur_jump_type = 3'd1; src = 2'd2; set_srt(0, 10); st[0] = 1'b1;
    @(negedge clk);
    st = '0; en[0] = 1'b1; last[0] = 1'b0;
    set_llr(0, 0, 3); set_llr(0, 1, -2); set_llr(0, 2, 4); set_llr(0, 3, -1);
    @(negedge clk);
    total++; if (upm_done !== 1'b0) begin bad++; $display("FAIL rep_done_mid: got %b exp 0", upm_done); end
    total++; if (pm(0, 0) !== 10'd5) begin bad++; $display("FAIL rep_hold_mid: got %0d exp 5", pm(0, 0)); end
    set_llr(0, 0, -6); set_llr(0, 1, 1); set_llr(0, 2, 1); set_llr(0, 3, 1); last[0] = 1'b1;
    @(negedge clk);
    en = '0; last = '0;
    total++; if (upm_done !== 1'b1) begin bad++; $display("FAIL rep_done: got %b exp 1", upm_done); end
    for (int k = 0; k < 4; k++) begin
      total++; if (pm(0, k) !== WID_PM'(exp_pm[k])) begin bad++; $display("FAIL rep_pm%0d: got %0d exp %0d", k, pm(0, k), exp_pm[k]); end
      total++; if (bv(0, k) !== 2'(exp_bv[k])) begin bad++; $display("FAIL rep_bv%0d: got %0d exp %0d", k, bv(0, k), exp_bv[k]); end
    end
  endtask

  task automatic test_frozen_sat();
    cur_jump_type = 3'd0; src = 2'd2; set_srt(0, 1020); st[0] = 1'b1;
    @(negedge clk);
    st = '0; en[0] = 1'b1; last[0] = 1'b1;
    set_llr(0, 0, -8); set_llr(0, 1, 0); set_llr(0, 2, 0); set_llr(0, 3, 0);
    @(negedge clk);
    en = '0; last = '0;
    for (int k = 0; k < 4; k++) begin
      total++; if (pm(0, k) !== 10'd1023) begin bad++; $display("FAIL frozen_pm%0d: got %0d exp 1023", k, pm(0, k)); end
      total++; if (bv(0, k) !== 2'd0) begin bad++; $display("FAIL frozen_bv%0d: got %0d exp 0", k, bv(0, k)); end
    end
  endtask

  task automatic test_info2();
    int exp_pm [4];
    exp_pm = '{3, 5, 0, 2};
    cur_jump_type = 3'd2; src = 2'd0; st[0] = 1'b1;
    @(negedge clk);
    st = '0; en[0] = 1'b1;
    set_llr(0, 0, 2); set_llr(0, 1, -3); set_llr(0, 2, -100); set_llr(0, 3, 50);
    @(negedge clk);
    en = '0;
    total++; if (upm_done !== 1'b1) begin bad++; $display("FAIL info_done: got %b exp 1", upm_done); end
    for (int k = 0; k < 4; k++) begin
      total++; if (pm(0, k) !== WID_PM'(exp_pm[k])) begin bad++; $display("FAIL info_pm%0d: got %0d exp %0d", k, pm(0, k), exp_pm[k]); end
      total++; if (bv(0, k) !== 2'(k)) begin bad++; $display("FAIL info_bv%0d: got %0d exp %0d", k, bv(0, k), k); end
    end
  endtask

  task automatic test_src_and_minllr();
    cur_jump_type = 3'd5; src = 2'd1; st[0] = 1'b1;
    @(negedge clk);
    st = '0; en[0] = 1'b1; set_llr(0, 0, 4); set_llr(0, 1, -50);
    @(negedge clk);
    en = '0;
    total++; if (pm(0, 0) !== 10'd3) begin bad++; $display("FAIL src1_pm0: got %0d exp 3", pm(0, 0)); end
    total++; if (pm(0, 1) !== 10'd7) begin bad++; $display("FAIL src1_pm1: got %0d exp 7", pm(0, 1)); end
    total++; if (pm(0, 2) !== 10'd1023) begin bad++; $display("FAIL src1_pm2: got %0d exp 1023", pm(0, 2)); end
    cur_jump_type = 3'd7; src = 2'd3; st[0] = 1'b1;
    @(negedge clk);
    st = '0; en[0] = 1'b1; set_llr(0, 0, -512);
    @(negedge clk);
    en = '0;
    total++; if (pm(0, 0) !== 10'd512) begin bad++; $display("FAIL minllr_pm0: got %0d exp 512", pm(0, 0)); end
    total++; if (pm(0, 1) !== 10'd0) begin bad++; $display("FAIL minllr_pm1: got %0d exp 0", pm(0, 1)); end
  endtask

  task automatic test_multi_path();
    path_valid[2*5 +: 2] = 2'b00; path_valid[2*6 +: 2] = 2'b11;
    cur_jump_type = 3'd2; src = 2'd2; set_srt(3, 100); set_srt(5, 50);
    st[3] = 1'b1; st[5] = 1'b1; st[6] = 1'b1;
    @(negedge clk);
    st = '0; st[3] = 1'b1; set_srt(3, 200);
    en[5] = 1'b1; en[6] = 1'b1;
    set_llr(5, 0, -7); set_llr(5, 1, 9); set_llr(6, 0, -7); set_llr(6, 1, 9);
    set_llr(3, 0, 2); set_llr(3, 1, -3);
    @(negedge clk);
    st = '0; en = '0; en[3] = 1'b1;
    total++; if (upm_done !== 1'b0) begin bad++; $display("FAIL multi_done_early: got %b exp 0", upm_done); end
    @(negedge clk);
    en = '0;
    total++; if (upm_done !== 1'b1) begin bad++; $display("FAIL multi_done: got %b exp 1", upm_done); end
    for (int k = 0; k < 4; k++) begin
      total++; if (pm(3, k) !== WID_PM'(200 + ((k == 0) ? 3 : (k == 1) ? 5 : (k == 2) ? 0 : 2)))
        begin bad++; $display("FAIL multi_p3_pm%0d: got %0d", k, pm(3, k)); end
      total++; if (pm(5, k) !== 10'd50) begin bad++; $display("FAIL multi_ck_pm%0d: got %0d exp 50", k, pm(5, k)); end
      total++; if (pm(6, k) !== 10'd1023) begin bad++; $display("FAIL multi_inv_pm%0d: got %0d exp 1023", k, pm(6, k)); end
      total++; if (bv(6, k) !== 2'd0) begin bad++; $display("FAIL multi_inv_bv%0d: got %0d exp 0", k, bv(6, k)); end
    end
    @(negedge clk);
    total++; if (upm_done !== 1'b0) begin bad++; $display("FAIL multi_done_once: got %b exp 0", upm_done); end
    path_valid = {NUM_PATH{2'b01}};
  endtask

  task automatic test_async_reset();
    int pulses;
    cur_jump_type = 3'd7; src = 2'd0; st[0] = 1'b1;
    @(negedge clk);
    st = '0;
    total++; if (pdec_clk_en3 !== 1'b1) begin bad++; $display("FAIL arst_clken_busy: got %b exp 1", pdec_clk_en3); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (pm_val !== '0) begin bad++; $display("FAIL arst_pm: got %h exp 0", pm_val); end
    total++; if (pdec_clk_en3 !== 1'b0) begin bad++; $display("FAIL arst_clken: got %b exp 0", pdec_clk_en3); end
    @(negedge clk);
    rst_n = 1'b1; en[0] = 1'b1; last[0] = 1'b1; set_llr(0, 0, -5);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      en = '0; last = '0;
      if (upm_done === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL arst_no_done: got %0d pulses exp 0", pulses); end
    total++; if (pm(0, 0) !== 10'd0) begin bad++; $display("FAIL arst_idle_en: got %0d exp 0", pm(0, 0)); end
`ifdef PDEC_UPM_MINNORM_EN
    path_valid = {NUM_PATH{2'b11}};
    for (int p = 0; p < 3; p++) path_valid[2*p +: 2] = 2'b01;
    cur_jump_type = 3'd7; src = 2'd0; st = 8'b0000_0111;
    @(negedge clk);
    st = '0; en = 8'b0000_0111;
    set_llr(0, 0, -7); set_llr(1, 0, -4); set_llr(2, 0, -9);
    @(negedge clk);
    en = '0;
    total++; if (upm_done !== 1'b0) begin bad++; $display("FAIL norm_done_early: got %b exp 0", upm_done); end
    total++; if (pdec_clk_en3 !== 1'b1) begin bad++; $display("FAIL norm_clken: got %b exp 1", pdec_clk_en3); end
    total++; if (pm(1, 0) !== 10'd4) begin bad++; $display("FAIL norm_pre: got %0d exp 4", pm(1, 0)); end
    @(negedge clk);
    total++; if (upm_done !== 1'b1) begin bad++; $display("FAIL norm_done: got %b exp 1", upm_done); end
    total++; if (pm(0, 0) !== 10'd3) begin bad++; $display("FAIL norm_p0: got %0d exp 3", pm(0, 0)); end
    total++; if (pm(1, 0) !== 10'd0) begin bad++; $display("FAIL norm_p1: got %0d exp 0", pm(1, 0)); end
    total++; if (pm(2, 0) !== 10'd5) begin bad++; $display("FAIL norm_p2: got %0d exp 5", pm(2, 0)); end
    total++; if (pm(2, 2) !== 10'd1023) begin bad++; $display("FAIL norm_max: got %0d exp 1023", pm(2, 2)); end
    path_valid = {NUM_PATH{2'b01}};
`endif
  endtask

  initial begin
    rst_n = 1'b0; cur_jump_type = 3'd0; path_valid = {NUM_PATH{2'b01}}; src = 2'd0;
    st = '0; en = '0; last = '0; llr_data = '0; srt_val = '0;
    test_reset();
    test_normal();
    test_rep();
    test_frozen_sat();
    test_info2();
    test_src_and_minllr();
    test_multi_path();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pdec_updt_pm_lx.md
Name: pdec_updt_pm_lx

Overview:
Parametrised path-metric update engine for the list polar decoder, successor to the fixed 8-path, single-beat PM unit. It serves NUM_PATH list paths. Per path it accumulates LLR penalties over one or more beats into up to 4 candidate PMs, then hands them to the PM sorter. It sits between the LLR update stage (ulr) and the sorter (srt), and reports completion to the top controller.

Parameters:
- WID_PM, 10: PM width, unsigned, saturating.
- WID_INN, 10: LLR width, signed two's complement.
- NUM_PATH, 8: number of list paths, 1..32.
- NUM_LLR, 4: LLRs per beat, per path; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pdec_clk_en3  out  1  ICG enable.
- cur_jump_type  in  3  node type: 0 frozen, 1 repetition, 2 info_2, 7 normal; others treated as 7.
- path_valid  in  2*NUM_PATH  per path: 00 CK, 01 valid, 11 invalid.
- ctrl2upm_pm_src_ind  in  2  base PM source: 0 zero, 1 own previous cand0, 2 sorter, 3 treated as 0.
- upm2ctrl_upm_done  out  1  single-cycle pulse when all started paths have finished.
- ulr2upm_llr_st  in  NUM_PATH  per-path node start; asserted 1 clk before the first llr_en.
- ulr2upm_llr_en  in  NUM_PATH  per-path beat valid.
- ulr2upm_llr_last  in  NUM_PATH  marks the last beat; qualified by llr_en.
- ulr2upm_llr_data  in  WID_INN*NUM_LLR*NUM_PATH  LLR beat per path, llr0 at the LSB.
- upm2uph_bit_val  out  2*4*NUM_PATH  2-bit hypothesis per candidate.
- upm2srt_pm_val  out  WID_PM*4*NUM_PATH  4 candidate PMs per path, cand0 at the LSB.
- srt2upm_pm_val  in  WID_PM*NUM_PATH  sorted survivor PMs.

Behaviour:
- Reset: all PM outputs 0, bit_val 0, done 0, every path FSM in IDLE, in-flight mask 0.
- Per-path FSM IDLE -> ACC -> FIN -> IDLE.
  - llr_st in any state: load base PM into all 4 accumulators, clear them otherwise, go to ACC. A restart discards any partial accumulation.
  - ACC: each llr_en beat adds penalties. llr_en with llr_last -> FIN.
  - FIN: lasts 1 cycle; register outputs, then go to IDLE.
- Base PM by src_ind:
  - 0: zero.
  - 1: this path's registered cand0.
  - 2: srt2upm_pm_val[path].
- Penalty for bit b on LLR x:
  - |x| when the hard decision (x<0 means 1) differs from b, else 0.
  - |-2^(WID_INN-1)| = 2^(WID_INN-1).
  - Every add saturates at 2^WID_PM-1.
- Per node type:
  - Frozen: multi-beat allowed. cand0 = all-zero hypothesis. cand1..3 = max.
  - Repetition: multi-beat allowed. cand0 = all-zero, cand1 = all-one. cand2..3 = max.
  - info_2: single beat; llr0 and llr1 only, other LLRs ignored. cand k = hypothesis {b1,b0} = k.
  - Normal: single beat, llr0 only. cand0 = bit 0, cand1 = bit 1. cand2..3 = max.
  - For single-beat types, llr_last is implied on the first beat.
- bit_val per candidate:
  - Frozen: 00.
  - Repetition: 00 / 11.
  - info_2: k.
  - Normal: 0 / 1.
  - Unused candidates: 00.
- Path gating:
  - CK path (path_valid[2i]=0) with type != 0: llr_en is ignored; the accumulators keep the base PM.
  - Invalid path (11): outputs are forced to max PM and bit_val 0.
- Outputs change only in the FIN cycle and hold until the next FIN. Latency from the last beat to valid PM is 1 cycle.
- Completion tracking:
  - The in-flight mask bit is set on llr_st and cleared on FIN.
  - upm_done pulses in the cycle after the mask goes nonzero -> zero, aligned with the last PM update.
  - A set and a clear on the same path in the same cycle: the set wins.
- pdec_clk_en3 = |llr_st | (in-flight mask != 0) | normalisation pending.

Optional Feature:
Macro PDEC_UPM_MINNORM_EN.
- Defined: when the mask empties, one extra cycle finds the minimum cand0 over valid, non-invalid paths. That minimum is subtracted from every non-max candidate PM; max stays max. upm_done then pulses 2 cycles after the mask empties instead of 1.
- Undefined: no normalisation; done timing as in Behaviour.

Test Plan:
1. Normal, src 0, path 0, llr0 = -5 -> cand0=5, cand1=0, bit_val 00/01; upm_done 1 clk after the beat.
2. Repetition, 2 beats {3,-2,4,-1}, {-6,1,1,1}, base 10 via src 2 -> cand0=10+2+1+6=19, cand1=10+3+4+1+1+1=20.
3. Frozen with base 1020, WID_PM=10, llr0=-8 -> cand0 saturates at 1023; cand1..3 = 1023.
4. info_2, llr0=2, llr1=-3, base 0 -> cand0..3 = 3, 5, 0, 2.
5. Path 3 restarted with llr_st mid-ACC; path 5 marked CK in info mode -> path 3 reflects only the second node; path 5 = base PM; upm_done pulses once.
6. Async reset during ACC -> outputs 0, pdec_clk_en3 = 0, no done pulse; with PDEC_UPM_MINNORM_EN defined, cand0s {7,4,9} -> {3,0,5}.
